// File: rtl/onehot_hold_decoder_pkg.sv
// ----------------------------------------------------------------------------
// onehot_hold_decoder_pkg
//   Shared constants and types for the one-hot hold decoder.
//   - ST_IDLE / ST_HOLD : FSM state encodings (1-bit, legacy-compatible)
//   - CODE_W            : width of the encoded channel number
//   - ONEHOT_W          : width of the regenerated one-hot strobe
// ----------------------------------------------------------------------------
package onehot_hold_decoder_pkg;

    localparam int CODE_W   = 2;
    localparam int ONEHOT_W = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef logic [CODE_W-1:0]   code_t;
    typedef logic [ONEHOT_W-1:0] onehot_t;

    // Assemble the two encoder bits into a code word (A1 is the MSB).
    function automatic code_t pack_code(input logic a1, input logic a0);
        return {a1, a0};
    endfunction

endpackage

// File: rtl/onehot_hold_decoder_if.sv
// ----------------------------------------------------------------------------
// onehot_hold_decoder_if
//   Encoder-side handshake between the 4-to-2 priority encoder and the
//   hold decoder.
//   - A1, A0 : encoded channel number (A1 is the MSB)
//   - V      : code valid; A1/A0 are don't-care when low
//   - RDY    : decoder can accept a code this cycle
//   master modport = encoder side, slave modport = decoder side.
// ----------------------------------------------------------------------------
interface onehot_hold_decoder_if;

    logic A1;
    logic A0;
    logic V;
    logic RDY;

    modport master (
        output A1,
        output A0,
        output V,
        input  RDY
    );

    modport slave (
        input  A1,
        input  A0,
        input  V,
        output RDY
    );

endinterface

// File: rtl/onehot_hold_decoder_decoder2to4.sv
// ----------------------------------------------------------------------------
// decoder2to4
//   Purely combinational 2-to-4 decoder with enable.
//   - en     : when low all outputs are low
//   - code   : channel number to select
//   - onehot : onehot[code] = en, all other bits low
// ----------------------------------------------------------------------------
module decoder2to4
    import onehot_hold_decoder_pkg::*;
(
    input  logic    en,
    input  code_t   code,
    output onehot_t onehot
);

    generate
        for (genvar gi = 0; gi < ONEHOT_W; gi++) begin : g_line
            assign onehot[gi] = en && (code == CODE_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/onehot_hold_decoder.sv
// ----------------------------------------------------------------------------
// onehot_hold_decoder
//   Regenerates a one-hot strobe from an encoded channel number and holds
//   each accepted code for HOLD_CYCLES cycles. A one-entry pending buffer
//   accepts the next code while the current one is still held, so
//   back-to-back codes play out with no idle gap.
//
//   Parameters
//   - HOLD_CYCLES : cycles each code is held (1..255)
//   - CNT_W       : hold counter width, 2^CNT_W > HOLD_CYCLES-1
//
//   Ports
//   - clk    : clock, rising edge
//   - rst    : synchronous active-high reset
//   - bus    : encoder handshake (A1, A0, V in; RDY out, combinational)
//   - Y0..Y3 : registered one-hot strobe for the active code
//   - BUSY   : registered, high while a code is held
// ----------------------------------------------------------------------------
module onehot_hold_decoder
    import onehot_hold_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    onehot_hold_decoder_if.slave  bus,
    output logic                  Y0,
    output logic                  Y1,
    output logic                  Y2,
    output logic                  Y3,
    output logic                  BUSY
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [0:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    code_t            active_reg, active_next;
    code_t            pend_reg, pend_next;
    logic             pend_full_reg, pend_full_next;
    onehot_t          y_reg, y_next;
    logic             busy_reg;

    logic             rdy;
    logic             transfer;
    logic             hold_next;
    code_t            in_code;

    // RDY only looks at rst and a register, never at V.
    assign rdy      = !rst && !pend_full_reg;
    assign bus.RDY  = rdy;
    assign transfer = bus.V && rdy;
    assign in_code  = pack_code(bus.A1, bus.A0);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        active_next    = active_reg;
        pend_next      = pend_reg;
        pend_full_next = pend_full_reg;

        if (state_reg == ST_IDLE) begin
            if (transfer) begin
                state_next  = ST_HOLD;
                active_next = in_code;
                cnt_next    = RELOAD;
            end
        end else begin
            if (cnt_reg != '0) begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (transfer) begin
                    pend_next      = in_code;
                    pend_full_next = 1'b1;
                end
            end else if (pend_full_reg) begin
                // Last hold cycle: promote the pending code so the new
                // line rises on the same edge the old one falls.
                active_next = pend_reg;
                cnt_next    = RELOAD;
                if (transfer) begin
                    pend_next = in_code;
                end else begin
                    pend_full_next = 1'b0;
                end
            end else if (transfer) begin
                active_next = in_code;
                cnt_next    = RELOAD;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    assign hold_next = (state_next == ST_HOLD);

    // Decode the next active code so Y is a clean register output and an
    // unchanged code keeps its line high without a glitch.
    decoder2to4 u_dec (
        .en     (hold_next),
        .code   (active_next),
        .onehot (y_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            active_reg    <= '0;
            pend_reg      <= '0;
            pend_full_reg <= 1'b0;
            y_reg         <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            active_reg    <= active_next;
            pend_reg      <= pend_next;
            pend_full_reg <= pend_full_next;
            y_reg         <= y_next;
            busy_reg      <= hold_next;
        end
    end

    assign Y0   = y_reg[0];
    assign Y1   = y_reg[1];
    assign Y2   = y_reg[2];
    assign Y3   = y_reg[3];
    assign BUSY = busy_reg;

endmodule

// File: doc/onehot_hold_decoder.md
# onehot_hold_decoder

Sequential 2-to-4 decoder that consumes the encoded output of the 4-to-2 priority encoder (A1, A0, V) and regenerates a one-hot strobe on Y3..Y0. Each accepted code is held on its one-hot line for a programmable number of cycles. A one-entry pending buffer lets a second code be accepted while the current one is still being held, so back-to-back codes play out with no idle gap. It sits at the far end of the encoder path and drives per-channel enables or grants.

## Interface
- HOLD_CYCLES, 4: cycles each accepted code is held on its Y line; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES-1.

- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- A1  input  1  code bit 1 (MSB) from the encoder.
- A0  input  1  code bit 0 from the encoder.
- V  input  1  code valid; A1/A0 are ignored when V=0.
- RDY  output  1  block can accept a code this cycle.
- Y0..Y3  output  1 each  registered one-hot strobe; Y[{A1,A0}] is high while that code is held.
- BUSY  output  1  registered; high while any code is being held.

## Operation
- **Transfer:** a transfer occurs at a rising edge where V=1, RDY=1 and rst=0. The code is {A1,A0}.
- **RDY:** combinational, RDY = !rst && !pend_full.
- **State IDLE:**
  - Y3..Y0 = 0000, BUSY=0.
  - On a transfer: active code <= input, cnt <= HOLD_CYCLES-1, go to HOLD.
- **State HOLD:** BUSY=1 and exactly one Y line is high, the one for the active code.
  - **cnt != 0:** cnt decrements. A transfer writes the pending buffer (pend <= code, pend_full <= 1).
  - **cnt == 0 (last hold cycle), pend_full=1:** active <= pend and cnt <= HOLD_CYCLES-1. A simultaneous transfer refills pend; otherwise pend_full <= 0.
  - **cnt == 0, pend_full=0, transfer:** active <= input code directly and cnt reloads.
  - **cnt == 0, pend_full=0, no transfer:** go to IDLE.
- **Same code back-to-back:** the Y line stays high continuously for 2×HOLD_CYCLES cycles; there is no glitch low.
- **Back-pressure:** when pend_full=1, RDY=0 and V is ignored. The upstream must hold the code until RDY=1.
- **HOLD_CYCLES=1:** each code occupies exactly one cycle. Streaming at V=1 every cycle sustains one code per cycle and pend is never filled.
- **Reset:** takes effect at the next edge with rst=1. State <= IDLE, cnt <= 0, pend_full <= 0 (pending code discarded), Y3..Y0 <= 0000, BUSY <= 0. Reset mid-hold truncates the hold with no further outputs.

## Timing
- **Reset values:** Y3..Y0=0000, BUSY=0. RDY=0 while rst=1 and RDY=1 in the first cycle after reset.
- **Latency:** a transfer at edge k raises the Y line and BUSY from edge k (visible in cycle k+1). The line stays high for exactly HOLD_CYCLES cycles.
- **Back-to-back:** a pending code's Y line rises at the same edge the previous line falls, with zero idle cycles.
- **RDY after a drain:** when pend drains, RDY returns high one cycle after the drain edge.
- **Throughput:** one code per HOLD_CYCLES cycles.
- **Fan-in:** RDY is the only combinational output; it depends on rst and a register only, with no path from V.

## Structure
- **Shared package (onehot_hold_decoder_pkg):**
  - state encodings ST_IDLE=1'b0, ST_HOLD=1'b1
  - CODE_W=2
  - ONEHOT_W=4
- **Sub-module decoder2to4:** purely combinational code-to-one-hot map, en && code → 4-bit one-hot. Instantiated once on the next-active code feeding the Y register.
- **Top-level contents:** FSM, hold counter, pend register and pend_full flag.

## Test plan
- **Reset:** assert rst for 2 cycles mid-hold with pend_full=1 → next edge Y=0000, BUSY=0. The pending code never appears and RDY=1 after rst falls.
- **Single code, HOLD_CYCLES=4:** transfer code 2'b10 from idle → Y2 high for exactly 4 cycles starting one cycle after the transfer edge, then Y=0000 and BUSY=0.
- **Back-to-back:** transfer 2'b01, then 2'b11 two cycles later → Y1 high for 4 cycles, Y3 rises on the same edge Y1 falls and is held 4 cycles, no idle gap. RDY is low from the pend write until the drain.
- **Back-pressure:** hold V=1 with codes 00, 01, 10 in sequence, advancing only when RDY=1 → the outputs sequence Y0, Y1, Y2, each held 4 cycles. No code is lost or duplicated and RDY toggles as specified.
- **HOLD_CYCLES=1 streaming:** V=1 every cycle with codes 3,2,1,0 → Y3,Y2,Y1,Y0 one cycle each on consecutive cycles, RDY constantly 1.
- **Ignore invalid:** V=0 with A1/A0 toggling, and V=1 while RDY=0 → no state change, no spurious Y pulses.
